// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs a byte stream into big-endian words, appends 0x80,
// zero fill and the 64-bit bit length, and hands each 16-word block to the hash core.
module sha1_msg_padder #(
  parameter int CNT_W = 29
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        blk_valid,
  output logic        blk_last,
  input  logic        blk_ready,
  output logic        done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ABSORB  = 3'd1;
  localparam logic [2:0] PAD80   = 3'd2;
  localparam logic [2:0] ZERO    = 3'd3;
  localparam logic [2:0] LEN     = 3'd4;
  localparam logic [2:0] HANDOFF = 3'd5;

  logic [2:0]       state;
  logic [5:0]       byte_idx;
  logic [31:0]      word_sr;
  logic [CNT_W-1:0] msg_cnt;
  logic [3:0]       widx;
  logic             pad_pending;
  logic             pad80_pending;
  logic             last_q;

  logic             accept;
  logic [1:0]       pos;
  logic [3:0]       cur_word;
  logic [31:0]      word_byte;
  logic [31:0]      word_pad;
  logic [31:0]      bit_len;

  assign accept   = in_valid & in_ready;
  assign pos      = byte_idx[1:0];
  assign cur_word = byte_idx[5:2];
  assign bit_len  = 32'({msg_cnt, 3'b000});

  // word_byte: current word with the incoming byte merged in at its slot.
  // word_pad:  current word with 0x80 at the next free slot and zeros after it.
  always_comb begin
    word_byte = word_sr;
    word_pad  = word_sr;
    case (pos)
      2'd0: begin
        word_byte[31:24] = in_data;
        word_pad         = 32'h8000_0000;
      end
      2'd1: begin
        word_byte[23:16] = in_data;
        word_pad         = {word_sr[31:24], 24'h80_0000};
      end
      2'd2: begin
        word_byte[15:8]  = in_data;
        word_pad         = {word_sr[31:16], 16'h8000};
      end
      default: begin
        word_byte[7:0]   = in_data;
        word_pad         = {word_sr[31:8], 8'h80};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      byte_idx      <= '0;
      word_sr       <= '0;
      msg_cnt       <= '0;
      widx          <= '0;
      pad_pending   <= 1'b0;
      pad80_pending <= 1'b0;
      last_q        <= 1'b0;
      in_ready      <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      blk_valid     <= 1'b0;
      blk_last      <= 1'b0;
      done          <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            word_sr  <= word_byte;
            byte_idx <= 6'd1;
            msg_cnt  <= CNT_W'(1);
            if (in_last) begin
              state    <= PAD80;
              in_ready <= 1'b0;
            end else begin
              state    <= ABSORB;
            end
          end
        end

        ABSORB: begin
          if (accept) begin
            byte_idx <= byte_idx + 6'd1;
            msg_cnt  <= msg_cnt + CNT_W'(1);
            if (pos == 2'd3) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_word;
              wr_data <= word_byte;
              word_sr <= '0;
            end else begin
              word_sr <= word_byte;
            end
            // A full block must be consumed before any padding may be written,
            // so a last byte that fills the block defers the 0x80 to the next one.
            if (byte_idx == 6'd63) begin
              state         <= HANDOFF;
              last_q        <= 1'b0;
              pad80_pending <= in_last;
              in_ready      <= 1'b0;
            end else if (in_last) begin
              state    <= PAD80;
              in_ready <= 1'b0;
            end
          end
        end

        PAD80: begin
          wr_en   <= 1'b1;
          wr_addr <= cur_word;
          wr_data <= word_pad;
          word_sr <= '0;
          if (cur_word <= 4'd12) begin
            widx  <= cur_word + 4'd1;
            state <= ZERO;
          end else if (cur_word == 4'd13) begin
            widx  <= 4'd14;
            state <= LEN;
          end else if (cur_word == 4'd14) begin
            widx        <= 4'd15;
            pad_pending <= 1'b1;
            state       <= ZERO;
          end else begin
            pad_pending <= 1'b1;
            last_q      <= 1'b0;
            state       <= HANDOFF;
          end
        end

        ZERO: begin
          // Fills up to word 13 before the length, or up to 15 when the
          // length has to spill into an extra block.
          wr_en   <= 1'b1;
          wr_addr <= widx;
          wr_data <= '0;
          widx    <= widx + 4'd1;
          if (pad_pending && widx == 4'd15) begin
            state  <= HANDOFF;
            last_q <= 1'b0;
          end else if (!pad_pending && widx == 4'd13) begin
            state <= LEN;
          end
        end

        LEN: begin
          wr_en   <= 1'b1;
          wr_addr <= widx;
          widx    <= widx + 4'd1;
          if (widx == 4'd14) begin
            wr_data <= '0;
          end else begin
            wr_data <= bit_len;
            last_q  <= 1'b1;
            state   <= HANDOFF;
          end
        end

        HANDOFF: begin
          // blk_valid rises one cycle late so the final word write lands first.
          if (!blk_valid) begin
            blk_valid <= 1'b1;
            blk_last  <= last_q;
          end else if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            if (blk_last) begin
              done     <= 1'b1;
              state    <= IDLE;
              byte_idx <= '0;
              word_sr  <= '0;
              in_ready <= 1'b1;
            end else if (pad_pending) begin
              pad_pending <= 1'b0;
              widx        <= '0;
              state       <= ZERO;
            end else if (pad80_pending) begin
              pad80_pending <= 1'b0;
              byte_idx      <= '0;
              state         <= PAD80;
            end else begin
              byte_idx <= '0;
              state    <= ABSORB;
              in_ready <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: random messages checked block-by-block against a
// byte-array padding model, plus directed boundary, backpressure and reset cases.
module tb_sha1_msg_padder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        blk_valid;
  logic        blk_last;
  logic        blk_ready = 1'b0;
  logic        done;

  sha1_msg_padder #(.CNT_W(29)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready), .done(done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [16];
  int          wcount = 0;
  logic [31:0] exp_w[$];
  bit          exp_last[$];
  logic [7:0]  mbuf [0:255];
  bit          cons_en = 1'b0;
  bit          prev_bv = 1'b0;
  bit          exp_done = 1'b0;
  int          done_cnt = 0;
  int          msgs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired waiting on DUT", name);
  endtask

  // Reference: padded message as a byte array, cut into 64-byte blocks.
  task automatic build_exp(input int L);
    int         total, nblk, o;
    logic [7:0] p [0:383];
    logic [31:0] bl;
    total = ((L + 8) / 64 + 1) * 64;
    nblk  = total / 64;
    for (int i = 0; i < total; i++) p[i] = (i < L) ? mbuf[i] : 8'h00;
    p[L] = 8'h80;
    bl = 32'(L * 8);
    p[total-4] = bl[31:24];
    p[total-3] = bl[23:16];
    p[total-2] = bl[15:8];
    p[total-1] = bl[7:0];
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 16; w++) begin
        o = b * 64 + w * 4;
        exp_w.push_back({p[o], p[o+1], p[o+2], p[o+3]});
      end
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  // Entered and left at posedge+1; each byte is held until in_ready was seen.
  task automatic send_msg(input int L, input bit gaps);
    int tmo;
    for (int i = 0; i < L; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = mbuf[i];
      in_last  = (i == L - 1);
      tmo = 0;
      while (!in_ready && tmo < 3000) begin
        @(posedge clk); #1;
        tmo++;
      end
      if (tmo >= 3000) begin
        fail_timeout("in_ready_wait");
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int tmo = 0;
    while (done_cnt < target && tmo < 5000) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (done_cnt < target) fail_timeout("done_wait");
    check("done_count", done_cnt, target);
    check("blocks_outstanding", exp_w.size(), 0);
  endtask

  // Block consumer: random ready, also asserted while no block is offered.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (cons_en) blk_ready = ($urandom_range(0, 2) == 0);
    end
  end

  // Per-cycle monitor: shadow block memory, invariants, done timing, block compare.
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        mem[wr_addr] = wr_data;
        wcount++;
      end
      check("wr_en_with_blk_valid", wr_en & blk_valid, 0);
      check("in_ready_with_blk_valid", in_ready & blk_valid, 0);
      if (done || exp_done) check("done_timing", done, exp_done);
      if (done) done_cnt++;
      exp_done = blk_valid && blk_ready && blk_last;
      if (blk_valid && !prev_bv) begin
        check("block_expected", exp_w.size() >= 16, 1);
        if (exp_w.size() >= 16) begin
          check("block_write_count", wcount, 16);
          for (int i = 0; i < 16; i++) check($sformatf("word%0d", i), mem[i], exp_w.pop_front());
          check("blk_last", blk_last, exp_last.pop_front());
        end
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
        wcount = 0;
      end
      prev_bv = blk_valid;
    end else begin
      prev_bv  = 1'b0;
      exp_done = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lb, tmo, L;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_last", blk_last, 0);
    check("rst_done", done, 0);
    reset   = 1'b1;
    cons_en = 1'b1;
    @(posedge clk); #1;

    // "abc"
    mbuf[0] = 8'h61; mbuf[1] = 8'h62; mbuf[2] = 8'h63;
    base = exp_w.size(); lb = exp_last.size();
    build_exp(3);
    check("model_abc_w0", exp_w[base], 32'h6162_6380);
    check("model_abc_w15", exp_w[base+15], 32'h0000_0018);
    check("model_abc_last", exp_last[lb], 1);
    send_msg(3, 1'b0); msgs++; wait_done(msgs);

    // 55 zero bytes: one block
    for (int i = 0; i < 55; i++) mbuf[i] = 8'h00;
    base = exp_w.size();
    build_exp(55);
    check("model_55_w13", exp_w[base+13], 32'h0000_0080);
    check("model_55_w15", exp_w[base+15], 32'h0000_01B8);
    check("model_55_nblk", exp_w.size() - base, 16);
    send_msg(55, 1'b1); msgs++; wait_done(msgs);

    // 56 bytes: length spills into a second block
    for (int i = 0; i < 56; i++) mbuf[i] = 8'($urandom);
    base = exp_w.size(); lb = exp_last.size();
    build_exp(56);
    check("model_56_b1w14", exp_w[base+14], 32'h8000_0000);
    check("model_56_b1w15", exp_w[base+15], 32'h0000_0000);
    check("model_56_b2w15", exp_w[base+31], 32'h0000_01C0);
    check("model_56_b1last", exp_last[lb], 0);
    send_msg(56, 1'b0); msgs++; wait_done(msgs);

    // 64 bytes 0x00..0x3F: second block starts with 0x80
    for (int i = 0; i < 64; i++) mbuf[i] = 8'(i);
    base = exp_w.size();
    build_exp(64);
    check("model_64_b1w0", exp_w[base], 32'h0001_0203);
    check("model_64_b2w0", exp_w[base+16], 32'h8000_0000);
    check("model_64_b2w15", exp_w[base+31], 32'h0000_0200);
    send_msg(64, 1'b1); msgs++; wait_done(msgs);

    // Backpressure: hold blk_ready low for 10 cycles with a byte waiting
    cons_en = 1'b0;
    blk_ready = 1'b0;
    for (int i = 0; i < 70; i++) mbuf[i] = 8'($urandom);
    build_exp(70);
    fork
      send_msg(70, 1'b0);
      begin
        tmo = 0;
        while (!blk_valid && tmo < 2000) begin
          @(posedge clk); #1;
          tmo++;
        end
        if (!blk_valid) fail_timeout("hold_blk_valid_wait");
        repeat (10) begin
          check("hold_blk_valid", blk_valid, 1);
          check("hold_in_ready", in_ready, 0);
          check("hold_wr_en", wr_en, 0);
          check("hold_in_valid_pending", in_valid, 1);
          @(posedge clk); #1;
        end
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
        check("release_blk_valid", blk_valid, 0);
        check("release_in_ready", in_ready, 1);
        cons_en = 1'b1;
      end
    join
    msgs++; wait_done(msgs);

    // Reset during ZERO aborts the message
    mbuf[0] = 8'h61; mbuf[1] = 8'h62; mbuf[2] = 8'h63;
    build_exp(3);
    send_msg(3, 1'b0);
    tmo = 0;
    while (!(wr_en && wr_addr == 4'd2) && tmo < 200) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (tmo >= 200) fail_timeout("zero_fill_wait");
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_wr_data", wr_data, 0);
    check("abort_blk_valid", blk_valid, 0);
    check("abort_blk_last", blk_last, 0);
    check("abort_done", done, 0);
    exp_w.delete();
    exp_last.delete();
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
    wcount = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    build_exp(3);
    send_msg(3, 1'b1); msgs++; wait_done(msgs);

    // Random lengths, including every boundary class
    for (int m = 0; m < 24; m++) begin
      case (m % 4)
        0:       L = 64 * $urandom_range(1, 3);
        1:       L = 64 * $urandom_range(0, 2) + $urandom_range(56, 63);
        2:       L = 64 * $urandom_range(0, 2) + 55;
        default: L = $urandom_range(1, 200);
      endcase
      for (int i = 0; i < L; i++) mbuf[i] = 8'($urandom);
      build_exp(L);
      send_msg(L, m[0]); msgs++; wait_done(msgs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
